rom_seq_ctrl: RTL and testbench

Sequencer that walks the command ROM and turns each 13-bit word into a bus action.
- On start_i it fetches words from a start address and decodes each one.
- Each word becomes a bus write, a delay, an event wait or end-of-program.
- Sits between the command ROM (1-cycle registered read with read enable) and the downstream register bus master.

---
 rtl/rom_seq_ctrl_pkg.sv | 36 +++
 rtl/rom_seq_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_rom_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_seq_ctrl_pkg.sv
// Shared decode constants and state/opcode types for the command ROM sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_WAIT  = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WRITE,
        S_DELAY,
        S_WAIT
    } state_e;

    localparam int unsigned OP_MSB      = 12;
    localparam int unsigned OP_LSB      = 11;
    localparam int unsigned FIELD_MSB   = 10;
    localparam int unsigned FIELD_LSB   = 0;
    localparam int unsigned FIELD_W     = FIELD_MSB - FIELD_LSB + 1;
    localparam int unsigned RADDR_MSB   = 10;
    localparam int unsigned RADDR_LSB   = 8;
    localparam int unsigned WDATA_MSB   = 7;
    localparam int unsigned WDATA_LSB   = 0;
    localparam int unsigned EVT_IDX_MSB = 2;
    localparam int unsigned EVT_IDX_LSB = 0;

    function automatic op_e decode_op(input logic [OP_MSB:0] word);
        return op_e'(word[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/rom_seq_ctrl.sv
// Walks the command ROM from a start address, turning each word into a bus
// write, a delay, an event wait or end-of-program.
module rom_seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned ROM_DEPTH   = 16,
    parameter int unsigned DATA_WIDTH  = 13,
    parameter int unsigned EVT_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           start_addr_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rom_addr_o,
    output logic                  rom_rden_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic [2:0]            bus_addr_o,
    output logic [7:0]            bus_data_o,
    input  logic [7:0]            event_i
);

    localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned TW = (EVT_TIMEOUT > 1) ? $clog2(EVT_TIMEOUT) : 1;
    localparam logic [AW-1:0] PC_LAST = AW'(ROM_DEPTH - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(EVT_TIMEOUT - 1);

    state_e               state_q;
    logic [AW-1:0]        pc_q;
    logic [AW-1:0]        pc_d;
    logic [FIELD_W-1:0]   dly_q;
    logic [TW-1:0]        tmo_q;
    logic [2:0]           idx_q;
    logic                 abort_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 rden_q;
    logic [AW-1:0]        rom_addr_q;
    logic                 bus_valid_q;
    logic [2:0]           bus_addr_q;
    logic [7:0]           bus_data_q;

    op_e                  op_w;
    logic [FIELD_W-1:0]   field_w;
    logic                 advance;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^start_addr_i[31:AW];

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rom_rden_o  = rden_q;
    assign rom_addr_o  = {{(32 - AW){1'b0}}, rom_addr_q};
    assign bus_valid_o = bus_valid_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_data_o  = bus_data_q;

    always_comb begin
        op_w    = decode_op(rom_data_i[OP_MSB:0]);
        field_w = rom_data_i[FIELD_MSB:FIELD_LSB];
        pc_d    = pc_q + 1'b1;
    end

    // Every instruction that completes normally funnels through one advance
    // request so the PC-overflow check lives in a single place.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            S_EXEC:  advance = !abort_i && (op_w == OP_DELAY) && (field_w == '0);
            S_WRITE: advance = bus_ready_i && !abort_pend_q && !abort_i;
            S_DELAY: advance = !abort_i && (dly_q == FIELD_W'(1));
            S_WAIT:  advance = !abort_i && event_i[idx_q];
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            dly_q        <= '0;
            tmo_q        <= '0;
            idx_q        <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rden_q       <= 1'b0;
            rom_addr_q   <= '0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rden_q     <= 1'b0;
            rom_addr_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pc_q         <= start_addr_i[AW-1:0];
                        rom_addr_q   <= start_addr_i[AW-1:0];
                        rden_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                        state_q      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        case (op_w)
                            OP_WRITE: begin
                                bus_addr_q  <= field_w[RADDR_MSB:RADDR_LSB];
                                bus_data_q  <= field_w[WDATA_MSB:WDATA_LSB];
                                bus_valid_q <= 1'b1;
                                state_q     <= S_WRITE;
                            end
                            OP_DELAY: begin
                                if (field_w != '0) begin
                                    dly_q   <= field_w;
                                    state_q <= S_DELAY;
                                end
                            end
                            OP_WAIT: begin
                                tmo_q   <= '0;
                                idx_q   <= field_w[EVT_IDX_MSB:EVT_IDX_LSB];
                                state_q <= S_WAIT;
                            end
                            OP_END: begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end

                S_WRITE: begin
                    // An abort seen while stalled waits for the handshake.
                    if (bus_ready_i) begin
                        bus_valid_q <= 1'b0;
                        if (abort_pend_q || abort_i) begin
                            abort_pend_q <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end else if (abort_i) begin
                        abort_pend_q <= 1'b1;
                    end
                end

                S_DELAY: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end

                S_WAIT: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!event_i[idx_q]) begin
                        if (tmo_q == T_LAST) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase

            if (advance) begin
                if (pc_q == PC_LAST) begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    pc_q       <= pc_d;
                    rom_addr_q <= pc_d;
                    rden_q     <= 1'b1;
                    state_q    <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Scoreboard bench for rom_seq_ctrl: a program-level timeline model predicts
// fetches, bus writes, termination pulses and end-of-busy cycles.
module tb_rom_seq_ctrl;

    localparam int DEPTH  = 16;
    localparam int EVT_TO = 1024;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] start_addr_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o, rom_rden_o, bus_valid_o;
    logic [31:0] rom_addr_o;
    logic [12:0] rom_data_i = '0;
    logic        bus_ready_i = 1'b0;
    logic [2:0]  bus_addr_o;
    logic [7:0]  bus_data_o;
    logic [7:0]  event_i = '0;

    always #5 clk = ~clk;

    rom_seq_ctrl #(.ROM_DEPTH(DEPTH), .DATA_WIDTH(13), .EVT_TIMEOUT(EVT_TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rom_addr_o(rom_addr_o), .rom_rden_o(rom_rden_o), .rom_data_i(rom_data_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o), .event_i(event_i)
    );

    typedef struct {int cyc; int addr;} fetch_t;
    typedef struct {bit is_err; int cyc;} term_t;

    logic [12:0]  mem [DEPTH];
    int           stall_k [DEPTH];
    int           wait_w [DEPTH];
    fetch_t       exp_fetch [$];
    logic [10:0]  exp_wr [$];
    term_t        exp_term [$];
    int           kq [$];
    bit [7:0]     ev_sched [int];

    int cyc = 0;
    int start_cyc = 1 << 30;
    bit run_on = 1'b0;
    int abort_at = -1;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_rden_o) rom_data_i <= mem[rom_addr_o[3:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] w_wr(input int a, input int d);
        return {2'b00, 3'(a), 8'(d)};
    endfunction
    function automatic logic [12:0] w_dly(input int n);
        return {2'b01, 11'(n)};
    endfunction
    function automatic logic [12:0] w_wait(input int idx);
        return {2'b10, 8'($urandom), 3'(idx)};
    endfunction
    function automatic logic [12:0] w_end();
        return {2'b11, 11'($urandom)};
    endfunction

    // Timeline model: cycle 0 is the first cycle after start is accepted.
    // Returns the cycle in which busy_o is first expected low.
    function automatic int predict(input int sa, input int ab);
        int t, pc, nxt, op, fld, k, w, idx;
        bit [7:0] mask;
        t = 0;
        pc = sa;
        for (int n = 0; n <= DEPTH; n++) begin
            exp_fetch.push_back('{t, pc});
            if (ab == t || ab == t + 1) return ab + 1;
            op  = int'(mem[pc]) >> 11;
            fld = int'(mem[pc]) & 'h7FF;
            if (op == 3) begin
                exp_term.push_back('{1'b0, t + 2});
                return t + 2;
            end else if (op == 0) begin
                k = stall_k[pc];
                kq.push_back(k);
                exp_wr.push_back(11'(fld));
                nxt = t + 3 + k;
                if (ab >= t + 2 && ab <= t + 2 + k) return nxt;
            end else if (op == 1) begin
                if (fld == 0) nxt = t + 2;
                else begin
                    if (ab >= t + 2 && ab <= t + 1 + fld) return ab + 1;
                    nxt = t + 2 + fld;
                end
            end else begin
                idx  = fld % 8;
                mask = 8'(1 << idx);
                w    = (wait_w[pc] < 0) ? EVT_TO : wait_w[pc];
                for (int c = 0; c < EVT_TO && c <= w; c++)
                    ev_sched[t + 2 + c] = (c == w) ? (8'($urandom) | mask) : (8'($urandom) & ~mask);
                if (w >= EVT_TO) begin
                    if (ab >= t + 2 && ab <= t + 1 + EVT_TO) return ab + 1;
                    exp_term.push_back('{1'b1, t + 2 + EVT_TO});
                    return t + 2 + EVT_TO;
                end
                if (ab >= t + 2 && ab <= t + 2 + w) return ab + 1;
                nxt = t + 3 + w;
            end
            if (pc == DEPTH - 1) begin
                exp_term.push_back('{1'b1, nxt});
                return nxt;
            end
            pc++;
            t = nxt;
        end
        return -1;
    endfunction

    // Input drivers: ready follows the per-write stall plan, events follow
    // the model's schedule, abort fires on its planned cycle.
    bit rdy_active = 1'b0;
    int rdy_cnt = 0;
    int cur_k = 0;
    int drv_rel;
    always begin
        @(posedge clk);
        #1;
        drv_rel = cyc - start_cyc;
        abort_i = run_on && (drv_rel == abort_at);
        event_i = (run_on && ev_sched.exists(drv_rel)) ? ev_sched[drv_rel] : 8'($urandom);
        if (rst_i) begin
            rdy_active  = 1'b0;
            bus_ready_i = 1'b0;
        end else if (bus_valid_o) begin
            if (!rdy_active) begin
                rdy_active = 1'b1;
                cur_k = (kq.size() > 0) ? kq.pop_front() : 0;
                rdy_cnt = 0;
            end
            bus_ready_i = (rdy_cnt == cur_k);
            if (rdy_cnt == cur_k) rdy_active = 1'b0;
            rdy_cnt++;
        end else begin
            bus_ready_i = 1'($urandom);
        end
    end

    fetch_t      mf;
    term_t       mt;
    logic [10:0] mw;
    int          mon_rel;
    bit          pv = 1'b0, pr = 1'b0;
    logic [10:0] pfield = '0;
    always @(negedge clk) begin
        if (rst_i) begin
            pv = 1'b0;
        end else begin
            mon_rel = cyc - start_cyc;
            if (rom_rden_o) begin
                if (exp_fetch.size() == 0) check("spurious_fetch", 64'(rom_addr_o), 64'hFFFF);
                else begin
                    mf = exp_fetch.pop_front();
                    check("fetch_addr", 64'(rom_addr_o), 64'(mf.addr));
                    check("fetch_cycle", 64'(mon_rel), 64'(mf.cyc));
                end
            end
            if (pv && !pr)
                check("valid_hold", 64'({bus_valid_o, bus_addr_o, bus_data_o}), 64'({1'b1, pfield}));
            if (bus_valid_o && bus_ready_i) begin
                if (exp_wr.size() == 0) check("spurious_write", 64'({bus_addr_o, bus_data_o}), 64'hFFFF);
                else begin
                    mw = exp_wr.pop_front();
                    check("write_data", 64'({bus_addr_o, bus_data_o}), 64'(mw));
                end
            end
            pv = bus_valid_o;
            pr = bus_ready_i;
            pfield = {bus_addr_o, bus_data_o};
            if (done_o || err_o) begin
                if (exp_term.size() == 0) check("spurious_term", 64'({done_o, err_o}), 64'd0);
                else begin
                    mt = exp_term.pop_front();
                    check("term_kind", 64'({done_o, err_o}), mt.is_err ? 64'd1 : 64'd2);
                    check("term_cycle", 64'(mon_rel), 64'(mt.cyc));
                    check("term_busy", 64'(busy_o), 64'd0);
                end
            end
        end
    end

    task automatic clear_prog();
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = w_end();
            stall_k[a] = 0;
            wait_w[a] = 0;
        end
    endtask

    task automatic do_run(input int sa, input int ab);
        int  e, r;
        bit  ended;
        e = predict(sa, ab);
        abort_at = ab;
        @(posedge clk);
        #1;
        start_cyc = cyc + 1;
        run_on = 1'b1;
        start_i = 1'b1;
        start_addr_i = ($urandom & 32'hFFFF_FFF0) | 32'(sa);
        ended = 1'b0;
        for (int i = 0; i < 20000 && !ended; i++) begin
            @(negedge clk);
            r = cyc - start_cyc;
            if (r == 0) check("busy_rise", 64'(busy_o), 64'd1);
            if (r >= 0 && !busy_o) begin
                check("end_cycle", 64'(r), 64'(e));
                ended = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                start_i = ((cyc - start_cyc) < e) ? 1'($urandom) : 1'b0;
            end
        end
        if (!ended) check("run_timeout", 64'd0, 64'd1);
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_on = 1'b0;
        abort_at = -1;
        check("queues_drained", 64'(exp_fetch.size() + exp_wr.size() + exp_term.size() + kq.size()), 64'd0);
        exp_fetch.delete(); exp_wr.delete(); exp_term.delete(); kq.delete();
        ev_sched.delete();
    endtask

    int  rnd_ab, rop;
    bit  got;
    initial begin
        clear_prog();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy_o, done_o, err_o, rom_rden_o, rom_addr_o, bus_valid_o, bus_addr_o, bus_data_o}), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);

        clear_prog(); mem[2] = w_wr(3, 8'h5A); mem[3] = w_end();
        do_run(2, -1);
        stall_k[2] = 4;
        do_run(2, -1);
        clear_prog(); mem[0] = w_dly(7); mem[1] = w_end();
        do_run(0, -1);
        mem[0] = w_dly(0);
        do_run(0, -1);
        clear_prog(); mem[0] = w_wait(5); mem[1] = w_end(); wait_w[0] = 18;
        do_run(0, -1);
        wait_w[0] = -1;
        do_run(0, -1);
        clear_prog(); mem[15] = w_wr(6, 8'hA5);
        do_run(15, -1);
        clear_prog(); mem[0] = w_dly(100); mem[1] = w_end();
        do_run(0, 30);
        clear_prog(); mem[0] = w_wr(5, 8'hC3); mem[1] = w_end(); stall_k[0] = 6;
        do_run(0, 4);

        clear_prog(); mem[0] = w_wr(1, 8'h33); stall_k[0] = 50;
        void'(predict(0, -1));
        @(posedge clk);
        #1;
        start_cyc = cyc + 1; run_on = 1'b1; start_i = 1'b1; start_addr_i = '0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus_valid_o;
        end
        check("rst_wr_valid_seen", 64'(got), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_clear", 64'({busy_o, done_o, err_o, rom_rden_o, rom_addr_o, bus_valid_o, bus_addr_o, bus_data_o}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        run_on = 1'b0;
        exp_fetch.delete(); exp_wr.delete(); exp_term.delete(); kq.delete();
        ev_sched.delete();

        for (int n = 0; n < 24; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
                rop = int'($urandom % 10);
                if (rop < 4)      mem[a] = {2'b00, 11'($urandom)};
                else if (rop < 7) mem[a] = w_dly(int'($urandom % 10));
                else if (rop < 9) mem[a] = w_wait(int'($urandom % 8));
                else              mem[a] = w_end();
                stall_k[a] = int'($urandom % 5);
                wait_w[a]  = ($urandom % 20 == 0) ? -1 : int'($urandom % 8);
            end
            rnd_ab = ($urandom % 4 == 0) ? int'($urandom % 40) : -1;
            do_run(int'($urandom % DEPTH), rnd_ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
